// File: rtl/vec_cpu_core.sv
// vec_cpu_core: single-cycle 32-bit CPU core with 16-bit instructions, eight
// 32-bit registers (R0 hard-wired to zero) and packed 4x8-bit lane arithmetic.
//
// Ports:
//   clk         in   1  single clock, all state updates on the rising edge
//   reset       in   1  asynchronous, active-low reset
//   instruction in  16  instruction at address pc (combinational imem)
//   mem_data    in  32  load data for cpu_addr (combinational dmem)
//   wr_enable   out  1  store strobe, memory writes cpu_data on the rising edge
//   pc          out 32  instruction index in halfword units
//   cpu_addr    out 32  data-memory address
//   cpu_data    out 32  store data
//
// Configuration macro: VEC_MUL_EN
//   defined   -> opcode 0x8 executes lane-wise 8x8 multiply (low 8 bits kept)
//   undefined -> opcode 0x8 behaves as NOP and no multipliers are built

module vec_cpu_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic [31:0] mem_data,
  output logic        wr_enable,
  output logic [31:0] pc,
  output logic [31:0] cpu_addr,
  output logic [31:0] cpu_data
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_VADD = 4'h6;
  localparam logic [3:0] OP_VSUB = 4'h7;
  localparam logic [3:0] OP_VMUL = 4'h8;
  localparam logic [3:0] OP_LI   = 4'h9;
  localparam logic [3:0] OP_SLLI = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hC;
  localparam logic [3:0] OP_BEQ  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Lane-wise add, each 8-bit lane wraps independently
  function automatic logic [31:0] lane_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = a[8*i +: 8] + b[8*i +: 8];
    end
    return r;
  endfunction

  // Lane-wise subtract, no borrow crosses a lane boundary
  function automatic logic [31:0] lane_sub(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = a[8*i +: 8] - b[8*i +: 8];
    end
    return r;
  endfunction

`ifdef VEC_MUL_EN
  // Lane-wise multiply keeping the low byte of each 16-bit product
  function automatic logic [31:0] lane_mul(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [15:0] p;
    r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      p = {8'd0, a[8*i +: 8]} * {8'd0, b[8*i +: 8]};
      r[8*i +: 8] = p[7:0];
    end
    return r;
  endfunction
`endif

  // Architectural state
  logic [1:0]  sync_r;
  logic        halted_r;
  logic [31:0] pc_r;
  logic [31:0] regs_r [0:7];

  // Decode fields
  logic [3:0]  op_s;
  logic [2:0]  rd_idx_s;
  logic [2:0]  rs1_idx_s;
  logic [2:0]  rs2_idx_s;
  logic [31:0] imm9_s;
  logic [31:0] imm6_s;
  logic [31:0] imm12_s;
  logic [4:0]  sh_s;
  logic [31:0] rd_val_s;
  logic [31:0] rs1_val_s;
  logic [31:0] rs2_val_s;

  // Execute results
  logic        wb_en_s;
  logic [31:0] wb_data_s;
  logic [31:0] next_pc_s;
  logic        mem_we_s;
  logic [31:0] addr_s;
  logic [31:0] data_s;
  logic        halt_s;
  logic        run_s;
  logic        commit_s;

  assign op_s      = instruction[15:12];
  assign rd_idx_s  = instruction[11:9];
  assign rs1_idx_s = instruction[8:6];
  assign rs2_idx_s = instruction[5:3];
  assign imm9_s    = {{23{instruction[8]}}, instruction[8:0]};
  assign imm6_s    = {{26{instruction[5]}}, instruction[5:0]};
  assign imm12_s   = {{20{instruction[11]}}, instruction[11:0]};
  assign sh_s      = instruction[4:0];

  // regs_r[0] is cleared by reset and never written, so R0 reads as zero.
  assign rd_val_s  = regs_r[rd_idx_s];
  assign rs1_val_s = regs_r[rs1_idx_s];
  assign rs2_val_s = regs_r[rs2_idx_s];

  // The first stage captures the release and the second holds it; the core
  // runs as soon as the first stage is set so the instruction at pc=0
  // commits on the second rising edge after reset rises.
  assign run_s    = sync_r[0] | sync_r[1];
  assign commit_s = run_s & ~halted_r;

  // Reset release synchronizer, asserted asynchronously, released on clk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], 1'b1};
    end
  end

  // Instruction decode and execute, all results combinational
  always_comb begin
    wb_en_s   = 1'b0;
    wb_data_s = 32'd0;
    next_pc_s = pc_r + 32'd1;
    mem_we_s  = 1'b0;
    addr_s    = 32'd0;
    data_s    = 32'd0;
    halt_s    = 1'b0;
    case (op_s)
      OP_NOP: begin
        wb_en_s = 1'b0;
      end
      OP_ADD: begin
        wb_en_s   = 1'b1;
        wb_data_s = rs1_val_s + rs2_val_s;
      end
      OP_SUB: begin
        wb_en_s   = 1'b1;
        wb_data_s = rs1_val_s - rs2_val_s;
      end
      OP_AND: begin
        wb_en_s   = 1'b1;
        wb_data_s = rs1_val_s & rs2_val_s;
      end
      OP_OR: begin
        wb_en_s   = 1'b1;
        wb_data_s = rs1_val_s | rs2_val_s;
      end
      OP_XOR: begin
        wb_en_s   = 1'b1;
        wb_data_s = rs1_val_s ^ rs2_val_s;
      end
      OP_VADD: begin
        wb_en_s   = 1'b1;
        wb_data_s = lane_add(rs1_val_s, rs2_val_s);
      end
      OP_VSUB: begin
        wb_en_s   = 1'b1;
        wb_data_s = lane_sub(rs1_val_s, rs2_val_s);
      end
`ifdef VEC_MUL_EN
      OP_VMUL: begin
        wb_en_s   = 1'b1;
        wb_data_s = lane_mul(rs1_val_s, rs2_val_s);
      end
`else
      OP_VMUL: begin
        wb_en_s = 1'b0;
      end
`endif
      OP_LI: begin
        wb_en_s   = 1'b1;
        wb_data_s = imm9_s;
      end
      OP_SLLI: begin
        wb_en_s   = 1'b1;
        wb_data_s = rs1_val_s << sh_s;
      end
      OP_LD: begin
        wb_en_s   = 1'b1;
        wb_data_s = mem_data;
        addr_s    = rs1_val_s;
      end
      OP_ST: begin
        mem_we_s = 1'b1;
        addr_s   = rs1_val_s;
        data_s   = rs2_val_s;
      end
      OP_BEQ: begin
        if (rd_val_s == rs1_val_s) begin
          next_pc_s = pc_r + imm6_s;
        end else begin
          next_pc_s = pc_r + 32'd1;
        end
      end
      OP_JMP: begin
        next_pc_s = pc_r + imm12_s;
      end
      OP_HALT: begin
        next_pc_s = pc_r;
        halt_s    = 1'b1;
      end
      default: begin
        wb_en_s = 1'b0;
      end
    endcase
  end

  // pc, halt flag and register file commit on the rising edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r     <= 32'd0;
      halted_r <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (commit_s) begin
      pc_r     <= next_pc_s;
      halted_r <= halt_s;
      if (wb_en_s && (rd_idx_s != 3'd0)) begin
        regs_r[rd_idx_s] <= wb_data_s;
      end
    end else begin
      pc_r     <= pc_r;
      halted_r <= halted_r;
    end
  end

  // Memory outputs are held at zero while reset is low, during the release
  // window and once halted.
  assign pc        = pc_r;
  assign wr_enable = reset & commit_s & mem_we_s;
  assign cpu_addr  = (reset & commit_s) ? addr_s : 32'd0;
  assign cpu_data  = (reset & commit_s) ? data_s : 32'd0;

endmodule

// File: tb/tb_vec_cpu_core.sv
// Directed testbench for vec_cpu_core: table-driven straight-line program
// plus hand-written reset, branch, jump and halt sequences.

module tb_vec_cpu_core;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [31:0] mem_data;
  logic        wr_enable;
  logic [31:0] pc;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data;

  logic [15:0] imem [0:4095];

  int checks;
  int failures;

  typedef struct {
    logic [15:0] instr;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[$];

  vec_cpu_core dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .mem_data    (mem_data),
    .wr_enable   (wr_enable),
    .pc          (pc),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instruction = imem[pc[11:0]];
  assign mem_data    = 32'h1234_5678;

  function automatic logic [15:0] e_r(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] e_li(input logic [2:0] rd, input logic [8:0] imm);
    return {4'h9, rd, imm};
  endfunction

  function automatic logic [15:0] e_sh(input logic [2:0] rd, input logic [2:0] rs1,
                                       input logic [4:0] sh);
    return {4'hA, rd, rs1, 1'b0, sh};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] ins, input logic we,
                     input logic [31:0] a, input logic [31:0] d);
    vec_t v;
    v.instr = ins;
    v.we    = we;
    v.addr  = a;
    v.data  = d;
    tbl.push_back(v);
  endtask

  // Assemble a 32-bit constant in rd a byte at a time, using R6 as scratch.
  task automatic build(input logic [2:0] rd, input logic [31:0] val);
    add(e_li(rd, {1'b0, val[31:24]}), 1'b0, 32'd0, 32'd0);
    for (int b = 2; b >= 0; b--) begin
      add(e_sh(rd, rd, 5'd8), 1'b0, 32'd0, 32'd0);
      add(e_li(3'd6, {1'b0, val[8*b +: 8]}), 1'b0, 32'd0, 32'd0);
      add(e_r(4'h4, rd, rd, 3'd6), 1'b0, 32'd0, 32'd0);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 4096; i++) imem[i] = 16'h0000;
  endtask

  // Assert reset mid-run, check the asynchronous effect, then release and
  // return just after the first rising edge following release.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_async_pc", pc, 32'd0);
    chk("rst_async_we", 32'(wr_enable), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_vmul;
    int          exp_pc2 [8];
    checks   = 0;
    failures = 0;

    // ---- Reset behaviour with a store sitting at pc=0 ----
    reset = 1'b0;
    clear_imem();
    imem[0] = 16'hC000;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_pc", pc, 32'd0);
    chk("reset_we", 32'(wr_enable), 32'd0);
    chk("reset_addr", cpu_addr, 32'd0);
    chk("reset_data", cpu_data, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_edge1_pc", pc, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("release_edge2_pc", pc, 32'd1);

    // ---- Straight-line program, one table row per executed cycle ----
`ifdef VEC_MUL_EN
    exp_vmul = 32'h0101_0100;
`else
    exp_vmul = 32'h0000_0055;
`endif
    add(e_li(3'd1, 9'd5), 1'b0, 32'd0, 32'd0);
    add(e_li(3'd2, 9'h1FD), 1'b0, 32'd0, 32'd0);
    add(e_r(4'h1, 3'd3, 3'd1, 3'd2), 1'b0, 32'd0, 32'd0);
    add(e_r(4'h2, 3'd4, 3'd2, 3'd1), 1'b0, 32'd0, 32'd0);
    add(e_li(3'd0, 9'd7), 1'b0, 32'd0, 32'd0);
    add(e_r(4'h1, 3'd5, 3'd0, 3'd0), 1'b0, 32'd0, 32'd0);
    add(e_r(4'hC, 3'd0, 3'd0, 3'd3), 1'b1, 32'd0, 32'h0000_0002);
    add(e_r(4'hC, 3'd0, 3'd0, 3'd4), 1'b1, 32'd0, 32'hFFFF_FFF8);
    add(e_r(4'hC, 3'd0, 3'd0, 3'd5), 1'b1, 32'd0, 32'h0000_0000);
    build(3'd1, 32'hFF01_7F10);
    build(3'd2, 32'h01FF_0110);
    add(e_r(4'h6, 3'd3, 3'd1, 3'd2), 1'b0, 32'd0, 32'd0);
    add(e_r(4'h7, 3'd4, 3'd1, 3'd2), 1'b0, 32'd0, 32'd0);
    add(e_li(3'd5, 9'h055), 1'b0, 32'd0, 32'd0);
    add(e_r(4'h8, 3'd5, 3'd1, 3'd1), 1'b0, 32'd0, 32'd0);
    add(e_r(4'hC, 3'd0, 3'd0, 3'd1), 1'b1, 32'd0, 32'hFF01_7F10);
    add(e_r(4'hC, 3'd0, 3'd0, 3'd2), 1'b1, 32'd0, 32'h01FF_0110);
    add(e_r(4'hC, 3'd0, 3'd0, 3'd3), 1'b1, 32'd0, 32'h0000_8020);
    add(e_r(4'hC, 3'd0, 3'd0, 3'd4), 1'b1, 32'd0, 32'hFE02_7E00);
    add(e_r(4'hC, 3'd0, 3'd0, 3'd5), 1'b1, 32'd0, exp_vmul);
    build(3'd1, 32'hDEAD_BEEF);
    add(e_li(3'd2, 9'h040), 1'b0, 32'd0, 32'd0);
    add(e_r(4'hC, 3'd0, 3'd2, 3'd1), 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    add(e_r(4'hB, 3'd3, 3'd2, 3'd0), 1'b0, 32'h0000_0040, 32'd0);
    add(e_r(4'hC, 3'd0, 3'd0, 3'd3), 1'b1, 32'd0, 32'h1234_5678);
    add(e_r(4'h5, 3'd4, 3'd1, 3'd2), 1'b0, 32'd0, 32'd0);
    add(e_r(4'h3, 3'd5, 3'd1, 3'd2), 1'b0, 32'd0, 32'd0);
    add(e_r(4'hC, 3'd0, 3'd0, 3'd4), 1'b1, 32'd0, 32'hDEAD_BEAF);
    add(e_r(4'hC, 3'd0, 3'd0, 3'd5), 1'b1, 32'd0, 32'h0000_0040);

    clear_imem();
    for (int i = 0; i < tbl.size(); i++) imem[i] = tbl[i].instr;
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      chk($sformatf("prog_pc[%0d]", i), pc, 32'(i));
      chk($sformatf("prog_we[%0d]", i), 32'(wr_enable), 32'(tbl[i].we));
      chk($sformatf("prog_addr[%0d]", i), cpu_addr, tbl[i].addr);
      chk($sformatf("prog_data[%0d]", i), cpu_data, tbl[i].data);
    end

    // ---- Branch taken then not taken at pc=10 ----
    clear_imem();
    imem[0]  = {4'hE, 12'd10};
    imem[8]  = e_li(3'd1, 9'd1);
    imem[10] = {4'hD, 3'd1, 3'd0, 6'b111110};
    imem[11] = 16'hF000;
    exp_pc2 = '{0, 10, 8, 9, 10, 11, 11, 11};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("branch_pc[%0d]", i), pc, 32'(exp_pc2[i]));
    end

    // ---- Maximum forward jump then halt ----
    clear_imem();
    imem[0]    = {4'hE, 12'h7FF};
    imem[2047] = 16'hF000;
    do_reset();
    @(negedge clk);
    chk("jmp_start_pc", pc, 32'd0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("halt_pc[%0d]", i), pc, 32'd2047);
      chk($sformatf("halt_we[%0d]", i), 32'(wr_enable), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
